// File: rtl/shr_operand_skid_pkg.sv
// shr_operand_skid_pkg: state encodings and default width shared by the datapath stages
package shr_operand_skid_pkg;
    localparam int DP_DATAWIDTH = 8;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;
endpackage

// File: rtl/shr_operand_skid_dp_entry_reg.sv
// dp_entry_reg: load-enabled entry register with synchronous clear
module dp_entry_reg #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] data_d, data_q;
    always_comb begin
        data_d = rst ? '0 : ld ? d : data_q;
    end
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end
    assign q = data_q;
endmodule

// File: rtl/shr_operand_skid.sv
// shr_operand_skid: two-entry skid buffer registering {a, sh_amt} for the SHR stage,
// flagging out-of-range shifts at capture and counting output transfers.
module shr_operand_skid
    import shr_operand_skid_pkg::*;
#(
    parameter int DATAWIDTH = DP_DATAWIDTH,
    parameter int CNTWIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_a,
    input  logic [DATAWIDTH-1:0] in_sh_amt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_a,
    output logic [DATAWIDTH-1:0] out_sh_amt,
    output logic                 out_zero,
    output logic [CNTWIDTH-1:0]  xfer_count
);
    localparam int EW = 2*DATAWIDTH + 1;
    localparam logic [DATAWIDTH:0] DW_C = (DATAWIDTH+1)'(DATAWIDTH);
    state_e state_d, state_q;
    logic in_ready_d, in_ready_q;
    logic [CNTWIDTH-1:0] cnt_d, cnt_q;
    logic in_fire, out_fire, head_ld, skid_ld;
    logic [EW-1:0] entry_in, head_in, head_q, skid_q;
    assign out_valid = state_q != ST_EMPTY;
    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;
    // Range flag is captured with the entry so the consumer never re-compares.
    assign entry_in  = {in_a, in_sh_amt, {1'b0, in_sh_amt} >= DW_C};
    always_comb begin
        head_ld = (state_q == ST_EMPTY && in_fire) ||
                  (state_q == ST_ONE && in_fire && out_fire) ||
                  (state_q == ST_FULL && out_fire);
        skid_ld = state_q == ST_ONE && in_fire && !out_fire;
        head_in = (state_q == ST_FULL) ? skid_q : entry_in;
        state_d = Rst ? ST_EMPTY :
                  (state_q == ST_EMPTY) ? (in_fire ? ST_ONE : ST_EMPTY) :
                  (state_q == ST_ONE) ? ((in_fire && !out_fire) ? ST_FULL :
                                         (!in_fire && out_fire) ? ST_EMPTY : ST_ONE) :
                  (state_q == ST_FULL) ? (out_fire ? ST_ONE : ST_FULL) : ST_EMPTY;
        in_ready_d = state_d != ST_FULL;
        cnt_d = Rst ? '0 : cnt_q + CNTWIDTH'(out_fire);
    end
    always_ff @(posedge Clk) begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
        cnt_q      <= cnt_d;
    end
    dp_entry_reg #(.W(EW)) u_head (
        .clk(Clk), .rst(Rst), .ld(head_ld), .d(head_in), .q(head_q)
    );
    dp_entry_reg #(.W(EW)) u_skid (
        .clk(Clk), .rst(Rst), .ld(skid_ld), .d(entry_in), .q(skid_q)
    );
    assign in_ready   = in_ready_q;
    assign out_a      = head_q[EW-1 -: DATAWIDTH];
    assign out_sh_amt = head_q[DATAWIDTH -: DATAWIDTH];
    assign out_zero   = head_q[0];
    assign xfer_count = cnt_q;
endmodule

// File: tb/tb_shr_operand_skid.sv
// tb_shr_operand_skid: directed stimulus with a queue model checked every cycle plus literal pins.
module tb_shr_operand_skid;
    logic Clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic [7:0] in_a, in_sh_amt;
    logic in_ready, out_valid, out_zero;
    logic [7:0] out_a, out_sh_amt;
    logic [15:0] xfer_count;
    logic in_ready_w, out_valid_w, out_zero_w;
    logic [7:0] out_a_w, out_sh_amt_w;
    logic [3:0] xfer_count_w;
    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] sh;
    } ent_t;
    ent_t mq[$];
    logic [31:0] mcnt = 0;

    always #5 Clk = ~Clk;

    shr_operand_skid #(.DATAWIDTH(8), .CNTWIDTH(16)) dut (
        .Clk(Clk), .Rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_sh_amt(in_sh_amt), .out_valid(out_valid),
        .out_ready(out_ready), .out_a(out_a), .out_sh_amt(out_sh_amt),
        .out_zero(out_zero), .xfer_count(xfer_count)
    );
    shr_operand_skid #(.DATAWIDTH(8), .CNTWIDTH(4)) dut_w (
        .Clk(Clk), .Rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_sh_amt(in_sh_amt), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_a(out_a_w), .out_sh_amt(out_sh_amt_w),
        .out_zero(out_zero_w), .xfer_count(xfer_count_w)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] a,
                         input logic [7:0] sh, input logic o);
        rst = r; in_valid = v; in_a = a; in_sh_amt = sh; out_ready = o;
        @(negedge Clk);
    endtask

    // Capacity-two FIFO model: accept when fewer than two held, deliver the oldest.
    always @(posedge Clk) begin
        bit ofire, ifire;
        if (rst) begin
            mq.delete();
            mcnt = 0;
        end else begin
            ofire = mq.size() > 0 && out_ready;
            ifire = in_valid && mq.size() < 2;
            if (ofire) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (ifire) mq.push_back('{in_a, in_sh_amt});
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("out_a", 32'(out_a), 32'(mq[0].a));
            chk("out_sh_amt", 32'(out_sh_amt), 32'(mq[0].sh));
            chk("out_zero", 32'(out_zero), 32'(mq[0].sh >= 8));
        end
        chk("xfer_count", 32'(xfer_count), 32'(mcnt[15:0]));
        chk("xfer_count_w", 32'(xfer_count_w), 32'(mcnt[3:0]));
    end

    initial begin
        logic [7:0] shr;
        drive(1, 1, 8'hAA, 8'd1, 0);
        drive(1, 1, 8'hAB, 8'd2, 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_xfer", 32'(xfer_count), 0);
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_out_sh", 32'(out_sh_amt), 0);
        chk("rst_out_zero", 32'(out_zero), 0);
        drive(0, 1, 8'hF0, 8'd3, 1);
        shr = out_a >> out_sh_amt;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_a", 32'(out_a), 32'h F0);
        chk("single_zero", 32'(out_zero), 0);
        chk("single_shr", 32'(shr), 32'h1E);
        drive(0, 0, 8'h00, 8'd0, 1);
        drive(0, 1, 8'h11, 8'd1, 0);
        chk("bp_ready1", 32'(in_ready), 1);
        drive(0, 1, 8'h22, 8'd2, 0);
        chk("bp_ready2", 32'(in_ready), 0);
        drive(0, 1, 8'h33, 8'd3, 0);
        chk("bp_hold_a", 32'(out_a), 32'h11);
        drive(0, 0, 8'hxx, 8'hxx, 0);
        chk("bp_x_a", 32'(out_a), 32'h11);
        drive(0, 1, 8'h33, 8'd3, 1);
        chk("bp_rel_a1", 32'(out_a), 32'h22);
        drive(0, 1, 8'h33, 8'd3, 1);
        chk("bp_rel_a2", 32'(out_a), 32'h33);
        drive(0, 0, 8'h00, 8'd0, 1);
        chk("bp_drained", 32'(out_valid), 0);
        drive(1, 0, 8'h00, 8'd0, 0);
        for (int i = 0; i < 100; i++) drive(0, 1, 8'(i * 7), 8'(i % 12), 1);
        drive(0, 0, 8'h00, 8'd0, 1);
        chk("stream_count", 32'(xfer_count), 100);
        drive(0, 1, 8'hFF, 8'd8, 1);
        chk("zero_sh8", 32'(out_zero), 1);
        drive(0, 1, 8'hFF, 8'hFF, 1);
        chk("zero_shFF", 32'(out_zero), 1);
        drive(0, 1, 8'hFF, 8'd7, 1);
        chk("zero_sh7", 32'(out_zero), 0);
        drive(0, 0, 8'h00, 8'd0, 1);
        drive(0, 1, 8'hA1, 8'd1, 0);
        drive(0, 1, 8'hA2, 8'd2, 0);
        chk("full_ready", 32'(in_ready), 0);
        drive(1, 1, 8'hA3, 8'd3, 1);
        chk("rstfull_valid", 32'(out_valid), 0);
        chk("rstfull_ready", 32'(in_ready), 1);
        drive(0, 0, 8'h00, 8'd0, 1);
        chk("rstfull_stays", 32'(out_valid), 0);
        drive(0, 1, 8'hB4, 8'd4, 1);
        chk("rstfull_fresh", 32'(out_a), 32'hB4);
        drive(0, 0, 8'h00, 8'd0, 1);
        drive(1, 0, 8'h00, 8'd0, 0);
        for (int i = 0; i < 17; i++) drive(0, 1, 8'(i), 8'(i % 9), 1);
        drive(0, 0, 8'h00, 8'd0, 1);
        chk("wrap_count16", 32'(xfer_count), 17);
        chk("wrap_count4", 32'(xfer_count_w), 1);
        drive(0, 0, 8'h00, 8'd0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
